rot_serializer: RTL

Downstream stage of the 8-bit barrel shifter: accepts each rotated byte from the shifter's `o_data` on a valid/ready handshake and emits it as a bit-serial stream with frame markers. A 2-entry holding buffer decouples the combinational shifter from the serial consumer. A consumer-side ready input allows back-pressure on every bit. Sits between the rotate datapath and the serial link driver.

---
 rtl/rot_serializer_if.sv | 28 ++
 rtl/rot_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rot_serializer_if.sv
// rot_serializer_if: byte-side valid/ready handshake plus the bit-serial
// output stream of rot_serializer, bundled so the design and the bench
// share one set of signal names.
interface rot_serializer_if #(
   parameter int DW = 8
);
   logic          i_valid;
   logic [DW-1:0] i_data;
   logic          o_ready;
   logic          o_sdata;
   logic          o_svalid;
   logic          i_sready;
   logic          o_sof;
   logic          o_eof;
   logic          o_busy;

   // Serializer side: consumes bytes and consumer ready, drives the stream.
   modport slave (
      input  i_valid, i_data, i_sready,
      output o_ready, o_sdata, o_svalid, o_sof, o_eof, o_busy
   );

   // Producer/consumer side: offers bytes, takes serial bits.
   modport master (
      output i_valid, i_data, i_sready,
      input  o_ready, o_sdata, o_svalid, o_sof, o_eof, o_busy
   );
endinterface

// File: rtl/rot_serializer.sv
// rot_serializer: takes rotated bytes from the barrel shifter through a
// 2-entry holding FIFO and streams them out bit-serially with sof/eof
// markers and per-bit back-pressure from the consumer.
// Optional feature macro: ROT_SERIALIZER_PARITY_EN appends an even-parity
// bit (XOR of the 8 data bits) to every frame; eof then marks that bit.
module rot_serializer #(
   parameter int DW        = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic             i_clk,
   input logic             i_rstn,
   rot_serializer_if.slave bus
);

`ifdef ROT_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DATA = 2'd1} state_t;
`endif

   state_t        state_q, state_d;
   logic [DW-1:0] mem_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    count_q, count_d;
   logic [DW-1:0] sreg_q, sreg_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [DW-1:0] head_s;
   logic          push_s, pop_s, try_load_s;
   logic          sdata_q, sdata_d;
   logic          svalid_q, svalid_d;
   logic          sof_q, sof_d;
   logic          eof_q, eof_d;
   logic          busy_q, busy_d;
`ifdef ROT_SERIALIZER_PARITY_EN
   logic          par_q, par_d;
`endif

   // Ready depends only on FIFO occupancy, never on the serial consumer.
   assign bus.o_ready  = (count_q != 2'd2);
   assign push_s       = bus.i_valid && bus.o_ready;
   assign head_s       = mem_q[rd_ptr_q];

   assign bus.o_sdata  = sdata_q;
   assign bus.o_svalid = svalid_q;
   assign bus.o_sof    = sof_q;
   assign bus.o_eof    = eof_q;
   assign bus.o_busy   = busy_q;

   // Frame sequencing: shift out bits on consumer ready, reload at frame end.
   always_comb begin
      state_d    = state_q;
      sreg_d     = sreg_q;
      cnt_d      = cnt_q;
      pop_s      = 1'b0;
      try_load_s = 1'b0;
`ifdef ROT_SERIALIZER_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         ST_IDLE: try_load_s = 1'b1;
         ST_DATA: begin
            if (bus.i_sready) begin
               sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
               cnt_d  = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
`ifdef ROT_SERIALIZER_PARITY_EN
                  state_d = ST_PAR;
`else
                  try_load_s = 1'b1;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef ROT_SERIALIZER_PARITY_EN
         ST_PAR: begin
            if (bus.i_sready) begin
               try_load_s = 1'b1;
            end else begin
               state_d = ST_PAR;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Frame boundary: start the next buffered byte with no gap, else idle.
      if (try_load_s) begin
         if (count_q != 2'd0) begin
            pop_s   = 1'b1;
            sreg_d  = head_s;
            cnt_d   = 3'd0;
            state_d = ST_DATA;
`ifdef ROT_SERIALIZER_PARITY_EN
            par_d   = ^head_s;
`endif
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         pop_s = 1'b0;
      end
   end

   // FIFO occupancy: simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Serial outputs are precomputed from next state so they leave a flop.
   always_comb begin
      svalid_d = (state_d != ST_IDLE);
      sof_d    = (state_d == ST_DATA) && (cnt_d == 3'd0);
      busy_d   = (state_d != ST_IDLE) || (count_d != 2'd0);
      if (state_d == ST_DATA) begin
         sdata_d = LSB_FIRST ? sreg_d[0] : sreg_d[DW-1];
`ifdef ROT_SERIALIZER_PARITY_EN
      end else if (state_d == ST_PAR) begin
         sdata_d = par_d;
`endif
      end else begin
         sdata_d = 1'b0;
      end
`ifdef ROT_SERIALIZER_PARITY_EN
      eof_d = (state_d == ST_PAR);
`else
      eof_d = (state_d == ST_DATA) && (cnt_d == 3'd7);
`endif
   end

   // State, FIFO and output registers; reset drops any frame and buffered bytes.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q  <= ST_IDLE;
         mem_q[0] <= {DW{1'b0}};
         mem_q[1] <= {DW{1'b0}};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         sreg_q   <= {DW{1'b0}};
         cnt_q    <= 3'd0;
         sdata_q  <= 1'b0;
         svalid_q <= 1'b0;
         sof_q    <= 1'b0;
         eof_q    <= 1'b0;
         busy_q   <= 1'b0;
`ifdef ROT_SERIALIZER_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         sdata_q  <= sdata_d;
         svalid_q <= svalid_d;
         sof_q    <= sof_d;
         eof_q    <= eof_d;
         busy_q   <= busy_d;
`ifdef ROT_SERIALIZER_PARITY_EN
         par_q    <= par_d;
`endif
         if (push_s) begin
            mem_q[wr_ptr_q] <= bus.i_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule
